cdc_2phase_dst_clearable: RTL and testbench
===========================================

CDC_2PHASE_DST_CLEARABLE -- requirements
Module: cdc_2phase_dst_clearable

Interface
REQ-001 SHALL have parameter WIDTH, default 41, payload width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of request synchronizer flops (>=2).
REQ-003 SHALL have port clk_i  input  1  destination-domain clock.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear_i  input  1  synchronous clear of handshake state, destination domain.
REQ-006 SHALL have port async_req_i  input  1  2-phase request toggle from the source side.
REQ-007 SHALL have port async_ack_o  output  1  2-phase acknowledge toggle to the source side.
REQ-008 SHALL have port async_data_i  input  WIDTH  payload from the source side, held stable while a request is outstanding.
REQ-009 SHALL have port data_o  output  WIDTH  captured payload, destination domain.
REQ-010 SHALL have port valid_o  output  1  payload on data_o available.
REQ-011 SHALL have port ready_i  input  1  downstream accepts data_o this cycle.

Function
REQ-012 SHALL pass async_req_i through a SYNC_STAGES-deep flop chain (req_sync) plus one extra flop (req_q).
REQ-013 SHALL detect a new token when req_sync != req_q and, on that clock edge, load async_data_i into data register data_q.
REQ-014 SHALL drive valid_o = (req_q != ack_q) && !clear_i.
REQ-015 SHALL drive data_o = data_q and async_ack_o = ack_q, both direct flop outputs with no combinational path from inputs.
REQ-016 SHALL toggle ack_q on an edge where valid_o && ready_i, completing exactly one transfer.
REQ-017 SHALL hold valid_o and data_o stable while valid_o && !ready_i, for any number of cycles.
REQ-018 SHALL assert valid_o after exactly SYNC_STAGES+1 rising clk_i edges, counted from the first edge that samples the changed async_req_i.
REQ-019 SHALL accept ready_i high in the same cycle valid_o first rises: ack_q toggles on the next edge, and valid_o deasserts after that edge.
REQ-020 SHALL leave data_q unchanged on any edge without a new-token detect.
REQ-021 SHALL, when clear_i is high, set ack_q to 0 on the next edge, hold valid_o low, and suppress any transfer; clear_i takes priority over a simultaneous valid_o && ready_i.
REQ-022 SHALL not clear the synchronizer chain or data_q on clear_i; system clear sequencing guarantees the source request is cleared to 0 concurrently.
REQ-023 SHALL tolerate ready_i high with valid_o low (no effect).
REQ-024 SHALL carry dont_touch attributes on the synchronizer, req_q, ack_q and data_q flops.

Reset
REQ-025 SHALL, while rst_ni is low, asynchronously force all synchronizer flops, req_q and ack_q to 0, so that valid_o=0 and async_ack_o=0.
REQ-026 SHALL not reset data_q; data_o is undefined until the first capture.
REQ-027 SHALL, on reset release mid-transfer, ignore the lost token; the source is reset in the same domain event.

Verification
REQ-028 SHALL verify single transfer (SYNC_STAGES=2): data 41'h1_2345_6789 with req toggling 0->1 and ready_i=1 -> valid_o high on the 3rd edge, data_o=41'h1_2345_6789, async_ack_o toggles to 1 on the 4th edge.
REQ-029 SHALL verify backpressure: ready_i=0 for 10 cycles after valid_o rises -> valid_o and data_o constant and async_ack_o unchanged; ready_i=1 -> one ack toggle.
REQ-030 SHALL verify back-to-back traffic: 100 random tokens driven by a source model with random ready_i -> every payload received in order, no duplicates, ack toggle count = 100.
REQ-031 SHALL verify a clear collision: clear_i=1 in the same cycle as valid_o && ready_i -> valid_o=0 that cycle, ack_q=0 next cycle, no transfer recorded.
REQ-032 SHALL verify reset mid-operation: rst_ni low while valid_o=1 -> valid_o=0 and async_ack_o=0 immediately (asynchronous); after release with req=0 -> no spurious valid for 20 cycles.

Source files
------------

// File: rtl/cdc_2phase_dst_clearable.sv
// Destination half of a 2-phase (toggle) request/acknowledge CDC with payload capture.
// Clear resets the handshake state only; the source drops its request in the same clear event.
module cdc_2phase_dst_clearable #(
   parameter int unsigned WIDTH       = 41,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             async_req_i,
   output logic             async_ack_o,
   input  logic [WIDTH-1:0] async_data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   (* dont_touch = "true" *) logic [SYNC_STAGES-1:0] req_sync_q;
   (* dont_touch = "true" *) logic                   req_q;
   (* dont_touch = "true" *) logic                   ack_q;
   (* dont_touch = "true" *) logic [WIDTH-1:0]       data_q;

   logic req_sync_s;
   logic new_token_s;
   logic valid_s;
   logic ack_d;

   assign req_sync_s = req_sync_q[SYNC_STAGES-1];

   // Handshake decode: token detect, valid qualification and acknowledge next state
   always_comb begin
      new_token_s = 1'b0;
      valid_s     = 1'b0;
      ack_d       = ack_q;
      new_token_s = (req_sync_s != req_q);
      valid_s     = (req_q != ack_q) && !clear_i;
      if (clear_i) begin
         ack_d = 1'b0;
      end else if (valid_s && ready_i) begin
         ack_d = ~ack_q;
      end else begin
         ack_d = ack_q;
      end
   end

   // Request synchronizer, request edge register and acknowledge toggle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_sync_q <= {SYNC_STAGES{1'b0}};
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], async_req_i};
         req_q      <= req_sync_s;
         ack_q      <= ack_d;
      end
   end

   // Payload capture; the source holds async_data_i stable while its request is open
   always_ff @(posedge clk_i) begin
      if (new_token_s) begin
         data_q <= async_data_i;
      end else begin
         data_q <= data_q;
      end
   end

   assign valid_o     = valid_s;
   assign data_o      = data_q;
   assign async_ack_o = ack_q;

endmodule

// File: tb/tb_cdc_2phase_dst_clearable.sv
// Directed and randomized bench for cdc_2phase_dst_clearable with a payload scoreboard.
module tb_cdc_2phase_dst_clearable;
   localparam int unsigned WIDTH       = 41;
   localparam int unsigned SYNC_STAGES = 2;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             clear_i;
   logic             async_req_i;
   logic             async_ack_o;
   logic [WIDTH-1:0] async_data_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;

   int               tests = 0;
   int               fails = 0;
   logic [WIDTH-1:0] exp_q[$];

   cdc_2phase_dst_clearable #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .async_req_i  (async_req_i),
      .async_ack_o  (async_ack_o),
      .async_data_i (async_data_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      async_data_i = d;
      async_req_i  = ~async_req_i;
      exp_q.push_back(d);
   endtask

   initial begin
      logic [WIDTH-1:0] exp_d;
      logic [WIDTH-1:0] clr_d;
      logic [63:0]      rnd;
      logic             ack_prev;
      int               rx_cnt;
      int               sent;
      int               ack_toggles;

      rst_ni       = 1'b0;
      clear_i      = 1'b0;
      async_req_i  = 1'b0;
      ready_i      = 1'b0;
      async_data_i = {WIDTH{1'b0}};
      repeat (3) tick();
      chk("reset_valid", valid_o, 1'b0);
      chk("reset_ack", async_ack_o, 1'b0);
      rst_ni = 1'b1;
      tick();

      // Single transfer: valid on the 3rd edge, ack toggles on the 4th
      ready_i = 1'b1;
      send(41'h1_2345_6789);
      tick();
      chk("single_valid_e1", valid_o, 1'b0);
      tick();
      chk("single_valid_e2", valid_o, 1'b0);
      chk("single_ack_e2", async_ack_o, 1'b0);
      tick();
      chk("single_valid_e3", valid_o, 1'b1);
      chk("single_ack_e3", async_ack_o, 1'b0);
      exp_d = exp_q.pop_front();
      chk("single_data", data_o, exp_d);
      tick();
      chk("single_ack_e4", async_ack_o, 1'b1);
      chk("single_valid_e4", valid_o, 1'b0);

      // Backpressure for 10 cycles, then exactly one acknowledge toggle
      ready_i = 1'b0;
      send(41'h0_DEAD_BEEF);
      repeat (SYNC_STAGES + 1) tick();
      chk("bp_valid_rise", valid_o, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid_hold", valid_o, 1'b1);
         chk("bp_data_hold", data_o, exp_q[0]);
         chk("bp_ack_hold", async_ack_o, 1'b1);
      end
      ready_i = 1'b1;
      exp_d = exp_q.pop_front();
      chk("bp_data_accept", data_o, exp_d);
      tick();
      chk("bp_ack_toggle", async_ack_o, 1'b0);
      chk("bp_valid_drop", valid_o, 1'b0);
      tick();
      chk("bp_ack_single", async_ack_o, 1'b0);

      // Clear colliding with valid && ready: no transfer, data_q retained
      ready_i = 1'b0;
      send(41'h1_5A5A_A5A5);
      repeat (SYNC_STAGES + 1) tick();
      chk("clr_valid_before", valid_o, 1'b1);
      clr_d = exp_q.pop_back();
      ready_i     = 1'b1;
      clear_i     = 1'b1;
      async_req_i = 1'b0;
      #1;
      chk("clr_valid_same", valid_o, 1'b0);
      tick();
      chk("clr_ack_next", async_ack_o, 1'b0);
      chk("clr_valid_next", valid_o, 1'b0);
      repeat (SYNC_STAGES) tick();
      clear_i = 1'b0;
      ready_i = 1'b0;
      #1;
      chk("clr_valid_after", valid_o, 1'b0);
      chk("clr_data_kept", data_o, clr_d);
      repeat (3) tick();
      chk("clr_valid_idle", valid_o, 1'b0);
      chk("clr_ack_idle", async_ack_o, 1'b0);

      // Back-to-back: 100 random tokens from a source model, random ready_i
      rx_cnt      = 0;
      sent        = 0;
      ack_toggles = 0;
      ack_prev    = async_ack_o;
      for (int cyc = 0; cyc < 5000 && rx_cnt < 100; cyc++) begin
         tick();
         if (async_ack_o !== ack_prev) begin
            ack_toggles++;
            ack_prev = async_ack_o;
         end
         ready_i = ($urandom_range(0, 3) != 0);
         if (valid_o && ready_i) begin
            chk("b2b_no_dup", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_d = exp_q.pop_front();
               chk("b2b_data", data_o, exp_d);
            end
            rx_cnt++;
         end
         if (sent < 100 && async_req_i == async_ack_o) begin
            rnd = {$urandom, $urandom};
            send(rnd[WIDTH-1:0]);
            sent++;
         end
      end
      tick();
      if (async_ack_o !== ack_prev) begin
         ack_toggles++;
      end
      ready_i = 1'b0;
      chk("b2b_rx_count", rx_cnt, 100);
      chk("b2b_ack_toggles", ack_toggles, 100);
      chk("b2b_queue_empty", exp_q.size(), 0);
      chk("b2b_ack_matches_req", async_ack_o, async_req_i);

      // Asynchronous reset while valid_o is high, then 20 quiet cycles
      rnd = {$urandom, $urandom};
      send(rnd[WIDTH-1:0]);
      repeat (SYNC_STAGES + 1) tick();
      chk("rst_valid_before", valid_o, 1'b1);
      exp_q.delete();
      #2;
      rst_ni      = 1'b0;
      async_req_i = 1'b0;
      #1;
      chk("rst_valid_async", valid_o, 1'b0);
      chk("rst_ack_async", async_ack_o, 1'b0);
      repeat (2) tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst_no_spurious", valid_o, 1'b0);
      end
      chk("rst_ack_quiet", async_ack_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
